// File: rtl/inert_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : inert_cmd_seq
// Purpose  : Command sequencer in front of SPI_mnrch. After reset it waits a
//            settle period, configures the iNEMO gyro (INT routing, ODR/range,
//            rounding) and then, for each data-ready INT, reads the yaw-rate
//            low (0xA6) and high (0xA7) bytes and publishes the signed 16-bit
//            result with a one-cycle valid strobe.
// Ports    : clk      in   system clock (posedge)
//            rst      in   synchronous active-high reset
//            INT      in   iNEMO data-ready (asynchronous, synchronised here)
//            done     in   SPI_mnrch transaction complete pulse
//            rd_data  in   SPI_mnrch read data, only [7:0] is meaningful
//            wrt      out  start SPI transaction, one-cycle pulse
//            cmd      out  SPI word; stable from wrt until done
//            yaw_rt   out  signed yaw rate {A7,A6}
//            vld      out  yaw_rt updated, one-cycle pulse
//            err      out  sticky WHO_AM_I mismatch flag
// Config   : INERT_WHOAMI_CHK_EN - adds a WHO_AM_I read (0x8F) before
//            configuration; a wrong ID parks the FSM in ERR with err set.
//            Undefined: no ID read, err tied low.
// Revision : 1.0  initial release
// ============================================================================
module inert_cmd_seq #(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        err
);

  typedef enum logic [3:0] {
    SETTLE   = 4'd0,
    ID       = 4'd1,
    CFG_INT  = 4'd2,
    CFG_G    = 4'd3,
    CFG_R    = 4'd4,
    WAIT_INT = 4'd5,
    RD_L     = 4'd6,
    RD_H     = 4'd7,
    PUBLISH  = 4'd8,
    ERR      = 4'd9
  } state_t;

`ifdef INERT_WHOAMI_CHK_EN
  localparam logic [7:0] WHOAMI_ID = 8'h6A;
`endif

  state_t            state, state_nxt;
  logic [INIT_W-1:0] cnt;
  logic              int_meta, int_sync;
  logic [7:0]        yaw_l;
  logic              is_cmd;
  logic              launch;
  logic [15:0]       cmd_nxt;

  // Upper read byte is don't-care from the sensor.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SETTLE;
    else     state <= state_nxt;
  end

  // Next-state logic. done only matters in command states.
  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE: begin
        if (&cnt) begin
`ifdef INERT_WHOAMI_CHK_EN
          state_nxt = ID;
`else
          state_nxt = CFG_INT;
`endif
        end
      end
      ID: begin
`ifdef INERT_WHOAMI_CHK_EN
        if (done) state_nxt = (rd_data[7:0] == WHOAMI_ID) ? CFG_INT : ERR;
`else
        state_nxt = SETTLE;
`endif
      end
      CFG_INT:  if (done) state_nxt = CFG_G;
      CFG_G:    if (done) state_nxt = CFG_R;
      CFG_R:    if (done) state_nxt = WAIT_INT;
      WAIT_INT: if (int_sync) state_nxt = RD_L;
      RD_L:     if (done) state_nxt = RD_H;
      RD_H:     if (done) state_nxt = PUBLISH;
      PUBLISH:  state_nxt = WAIT_INT;
      ERR:      state_nxt = ERR;
      default:  state_nxt = SETTLE;
    endcase
  end

  // Command decode for the state being entered. A transaction is launched only
  // on entry, so wrt is a single pulse per command state and cmd is loaded in
  // the same edge, staying put until the state is left.
  always_comb begin
    cmd_nxt = cmd;
    is_cmd  = 1'b1;
    case (state_nxt)
      ID:      cmd_nxt = 16'h8F00;
      CFG_INT: cmd_nxt = 16'h0D02;
      CFG_G:   cmd_nxt = 16'h1160;
      CFG_R:   cmd_nxt = 16'h1440;
      RD_L:    cmd_nxt = 16'hA600;
      RD_H:    cmd_nxt = 16'hA700;
      default: is_cmd  = 1'b0;
    endcase
    launch = is_cmd && (state_nxt != state);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      int_meta <= 1'b0;
      int_sync <= 1'b0;
      wrt      <= 1'b0;
      cmd      <= 16'h0000;
      yaw_l    <= 8'h00;
      yaw_rt   <= 16'h0000;
      vld      <= 1'b0;
    end else begin
      int_meta <= INT;
      int_sync <= int_meta;
      if (state == SETTLE) cnt <= cnt + 1'b1;
      wrt <= launch;
      if (launch) cmd <= cmd_nxt;
      if (state == RD_L && done) yaw_l <= rd_data[7:0];
      // High byte goes straight into yaw_rt together with the held low byte,
      // so the published word is always a single sample. yaw_rt and vld both
      // take effect as the FSM enters PUBLISH.
      if (state == RD_H && done) yaw_rt <= {rd_data[7:0], yaw_l};
      vld <= (state_nxt == PUBLISH);
    end
  end

`ifdef INERT_WHOAMI_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                                err <= 1'b0;
    else if (state == ID && state_nxt == ERR) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
